// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson-counter phase monitor.
package johnson_pkg;

  localparam int JN       = 8;
  localparam int NPH      = 2 * JN;
  localparam int CODE_MAX = 64;

  typedef enum logic [1:0] {
    S_INIT,
    S_TRACK,
    S_RESYNC
  } jpm_state_t;

  // Canonical n-bit Johnson code of phase k, zero-extended to CODE_MAX bits.
  function automatic logic [CODE_MAX-1:0] johnson_code(input int n, input int k);
    logic [CODE_MAX-1:0] c;
    c = '0;
    for (int i = 0; i < CODE_MAX; i++) begin
      if (i < n) begin
        if (k <= n) c[i] = (i < k);
        else        c[i] = (i >= k - n);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// Combinational decode of a registered Johnson sample into {legal, phase}.
module johnson_phase_decode
  import johnson_pkg::*;
#(
  parameter int N  = 8,
  parameter int PW = 4
) (
  input  logic [N-1:0]  q_r,
  output logic          legal,
  output logic [PW-1:0] k
);

  int                  ones;
  int                  kk;
  logic [CODE_MAX-1:0] code;

  always_comb begin
    ones = 0;
    for (int i = 0; i < N; i++) ones = ones + int'(q_r[i]);
    // Upper half of the cycle is recognised by the MSB; all-ones lands on N either way.
    kk    = q_r[N-1] ? (2 * N - ones) : ones;
    code  = johnson_code(N, kk);
    k     = PW'(kk);
    legal = (code == {{(CODE_MAX - N){1'b0}}, q_r});
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Registers a Johnson counter bus, decodes its phase and flags illegal codes/steps.
// Optional one-hot phase output is enabled with `define JPM_ONEHOT_EN.
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int N  = 8,
  parameter int PW = 4,
  parameter int WW = 8,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  q,
  input  logic          err_clr,
  output logic [PW-1:0] phase,
  output logic          valid,
  output logic          illegal,
  output logic          step_err,
  output logic [WW-1:0] wraps,
  output logic [EW-1:0] err_cnt,
  output logic          sticky_err
`ifdef JPM_ONEHOT_EN
  ,
  output logic [2*N-1:0] phase_oh
`endif
);

  localparam int              NPHASE  = 2 * N;
  localparam logic [PW-1:0]   PH_LAST = PW'(NPHASE - 1);

  function automatic logic [EW-1:0] sat_inc(input logic [EW-1:0] v);
    return (v == {EW{1'b1}}) ? v : v + EW'(1);
  endfunction

  logic [N-1:0]  q_p0_q, q_p0_d;
  logic          vld_p0_q, vld_p0_d;
  jpm_state_t    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          valid_q, valid_d;
  logic          illegal_q, illegal_d;
  logic          step_err_q, step_err_d;
  logic [WW-1:0] wraps_q, wraps_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic          sticky_q, sticky_d;
  logic          legal;
  logic [PW-1:0] k;
  logic [PW-1:0] ph_inc;

  johnson_phase_decode #(
    .N  (N),
    .PW (PW)
  ) u_decode (
    .q_r   (q_p0_q),
    .legal (legal),
    .k     (k)
  );

  assign ph_inc = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);

  always_comb begin
    q_p0_d     = q;
    vld_p0_d   = 1'b1;
    state_d    = state_q;
    phase_d    = phase_q;
    valid_d    = valid_q;
    illegal_d  = 1'b0;
    step_err_d = 1'b0;
    wraps_d    = wraps_q;
    err_cnt_d  = err_cnt_q;
    sticky_d   = sticky_q;

    // vld_p0 keeps the reset value of q_p0 from being mistaken for a sample.
    if (vld_p0_q) begin
      case (state_q)
        S_TRACK: begin
          if (legal) begin
            phase_d = k;
            if (k == phase_q || k == ph_inc) begin
              if (phase_q == PH_LAST && k == '0) wraps_d = wraps_q + WW'(1);
            end else begin
              step_err_d = 1'b1;
            end
          end else begin
            illegal_d = 1'b1;
            valid_d   = 1'b0;
            state_d   = S_RESYNC;
          end
        end
        default: begin
          if (legal) begin
            phase_d = k;
            valid_d = 1'b1;
            state_d = S_TRACK;
          end else begin
            illegal_d = 1'b1;
          end
        end
      endcase
    end

    // A fresh error outranks a simultaneous clear.
    if (illegal_d | step_err_d) begin
      err_cnt_d = err_clr ? EW'(1) : sat_inc(err_cnt_q);
      sticky_d  = 1'b1;
    end else if (err_clr) begin
      err_cnt_d = '0;
      sticky_d  = 1'b0;
    end
  end

`ifdef JPM_ONEHOT_EN
  logic [NPHASE-1:0] phase_oh_q, phase_oh_d;

  always_comb begin
    phase_oh_d = '0;
    if (valid_d) phase_oh_d[phase_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase_oh_q <= '0;
    else        phase_oh_q <= phase_oh_d;
  end

  assign phase_oh = phase_oh_q;
`endif

  // Stage p0: capture raw bus; stage p1: decode/check into output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_p0_q     <= '0;
      vld_p0_q   <= 1'b0;
      state_q    <= S_INIT;
      phase_q    <= '0;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      step_err_q <= 1'b0;
      wraps_q    <= '0;
      err_cnt_q  <= '0;
      sticky_q   <= 1'b0;
    end else begin
      q_p0_q     <= q_p0_d;
      vld_p0_q   <= vld_p0_d;
      state_q    <= state_d;
      phase_q    <= phase_d;
      valid_q    <= valid_d;
      illegal_q  <= illegal_d;
      step_err_q <= step_err_d;
      wraps_q    <= wraps_d;
      err_cnt_q  <= err_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign phase      = phase_q;
  assign valid      = valid_q;
  assign illegal    = illegal_q;
  assign step_err   = step_err_q;
  assign wraps      = wraps_q;
  assign err_cnt    = err_cnt_q;
  assign sticky_err = sticky_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed bench for johnson_phase_monitor (N=8): counting, illegal codes, step errors, saturation, reset.
module tb_johnson_phase_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  q;
  logic        err_clr;
  logic [3:0]  phase;
  logic        valid;
  logic        illegal;
  logic        step_err;
  logic [7:0]  wraps;
  logic [7:0]  err_cnt;
  logic        sticky_err;
`ifdef JPM_ONEHOT_EN
  logic [15:0] phase_oh;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  johnson_phase_monitor #(
    .N  (8),
    .PW (4),
    .WW (8),
    .EW (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .q          (q),
    .err_clr    (err_clr),
    .phase      (phase),
    .valid      (valid),
    .illegal    (illegal),
    .step_err   (step_err),
    .wraps      (wraps),
    .err_cnt    (err_cnt),
    .sticky_err (sticky_err)
`ifdef JPM_ONEHOT_EN
    ,
    .phase_oh   (phase_oh)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [3:0] ph;
    logic       vld;
    logic [7:0] wr;
  } vec_t;

  vec_t       t1[17];
  logic [7:0] codes[16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                            8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] ph, input logic vld,
                           input logic ill, input logic stp, input logic [7:0] wr,
                           input logic [7:0] ec, input logic st);
`ifdef JPM_ONEHOT_EN
    logic [15:0] oh;
    oh = '0;
    if (vld) oh[ph] = 1'b1;
    chk({tag, ".phase_oh"}, 32'(phase_oh), 32'(oh));
`endif
    chk({tag, ".phase"},    32'(phase),      32'(ph));
    chk({tag, ".valid"},    32'(valid),      32'(vld));
    chk({tag, ".illegal"},  32'(illegal),    32'(ill));
    chk({tag, ".step_err"}, 32'(step_err),   32'(stp));
    chk({tag, ".wraps"},    32'(wraps),      32'(wr));
    chk({tag, ".err_cnt"},  32'(err_cnt),    32'(ec));
    chk({tag, ".sticky"},   32'(sticky_err), 32'(st));
  endtask

  // Apply one sample (and err_clr) for one edge; expected values reflect the previous sample.
  task automatic cyc(input string tag, input logic [7:0] qv, input logic clr,
                     input logic [3:0] ph, input logic vld, input logic ill, input logic stp,
                     input logic [7:0] wr, input logic [7:0] ec, input logic st);
    q       = qv;
    err_clr = clr;
    @(posedge clk);
    #1;
    check_out(tag, ph, vld, ill, stp, wr, ec, st);
  endtask

  initial begin
    reset   = 1'b0;
    q       = 8'h00;
    err_clr = 1'b0;

    for (int i = 0; i < 17; i++) begin
      t1[i].q   = codes[i % 16];
      t1[i].ph  = (i == 0) ? 4'd0 : 4'(i - 1);
      t1[i].vld = (i != 0);
      t1[i].wr  = 8'd0;
    end

    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    reset = 1'b1;

    // Full count 0..15,0
    for (int i = 0; i < 17; i++) begin
      cyc($sformatf("count%0d", i), t1[i].q, 1'b0, t1[i].ph, t1[i].vld, 1'b0, 1'b0,
          t1[i].wr, 8'd0, 1'b0);
    end

    // Illegal code mid-count, then resync without step error
    cyc("wrap",     8'h01, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0);
    cyc("pre_ill",  8'h05, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0);
    cyc("ill",      8'h03, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 1'b1);
    cyc("resync",   8'h07, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1);

    // Jump 3 -> 6, then hold
    cyc("ph3",      8'h3F, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1);
    cyc("jump",     8'h3F, 1'b0, 4'd6, 1'b1, 1'b0, 1'b1, 8'd1, 8'd2, 1'b1);
    cyc("hold1",    8'h3F, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 8'd1, 8'd2, 1'b1);
    cyc("hold2",    8'h3F, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 8'd1, 8'd2, 1'b1);

    // 300 illegal samples: counter saturates
    for (int j = 0; j < 300; j++) begin
      if (j == 0)
        cyc("hold3", 8'h05, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 8'd1, 8'd2, 1'b1);
      else
        cyc($sformatf("sat%0d", j), 8'h05, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 8'd1,
            8'((2 + j > 255) ? 255 : 2 + j), 1'b1);
    end
    cyc("clr_err",  8'h05, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 1'b1);
    cyc("post_clr", 8'h07, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2, 1'b1);
    cyc("resync2",  8'h0F, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 8'd1, 8'd2, 1'b1);
    cyc("clr_only", 8'h1F, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0);

    // Advance to phase 9, then reset asynchronously
    cyc("ph5",      8'h3F, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0);
`ifdef JPM_ONEHOT_EN
    chk("oh_ph5", 32'(phase_oh), 32'h0020);
`endif
    cyc("ph6",      8'h7F, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0);
    cyc("ph7",      8'hFF, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0);
    cyc("ph8",      8'hFE, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0);
    cyc("ph9",      8'hFC, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0);

    #2;
    reset = 1'b0;
    #1;
    check_out("rst_async", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    @(posedge clk);
    #1;
    check_out("rst_hold", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    reset = 1'b1;

    // Restart at phase 12: accepted without step error
    cyc("restart0", 8'hF0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    cyc("restart1", 8'hE0, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    cyc("restart2", 8'hC0, 1'b0, 4'd13, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    cyc("restart3", 8'h80, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
